// File: rtl/pipe_adder.sv
// pipe_adder: N-bit add/subtract split into SEGS carry-chained segments, one per pipeline stage.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipe_adder #(
   parameter int N    = 32,
   parameter int SEGS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout
`ifdef PIPE_ADDER_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int W = N / SEGS;

   generate
      if ((SEGS < 1) || (N % SEGS != 0)) begin : gBadParams
         $error("pipe_adder: N must be a positive multiple of SEGS");
      end
   endgenerate

   logic         advance;
   logic [N-1:0] bEff;
   logic         c0;

   // The stall is global: one blocked output freezes every stage.
   assign advance  = !(out_valid && !out_ready);
   assign in_ready = advance;
   assign bEff     = sub ? ~b : b;
   assign c0       = sub ? 1'b1 : cin;

   genvar k;
   generate
      for (k = 0; k < SEGS; k++) begin : gStage
         localparam int DONE = (k + 1) * W;

         logic [W-1:0]    aSeg;
         logic [W-1:0]    bSeg;
         logic [W-1:0]    segD;
         logic            carryIn;
         logic            carryD;
         logic            validIn;
         logic [DONE-1:0] resD;
         logic [DONE-1:0] resQ;
         logic            carryQ;
         logic            validQ;

         if (k == 0) begin : gHead
            assign aSeg    = a[W-1:0];
            assign bSeg    = bEff[W-1:0];
            assign carryIn = c0;
            assign validIn = in_valid;
            assign resD    = segD;
         end else begin : gBody
            assign aSeg    = gStage[k-1].gOps.aRemQ[W-1:0];
            assign bSeg    = gStage[k-1].gOps.bRemQ[W-1:0];
            assign carryIn = gStage[k-1].carryQ;
            assign validIn = gStage[k-1].validQ;
            assign resD    = {segD, gStage[k-1].resQ};
         end

         assign {carryD, segD} = {1'b0, aSeg} + {1'b0, bSeg} + {{W{1'b0}}, carryIn};

         // Operand bits not yet consumed ride along until their own stage.
         if (k < SEGS - 1) begin : gOps
            logic [N-DONE-1:0] aRemD;
            logic [N-DONE-1:0] bRemD;
            logic [N-DONE-1:0] aRemQ;
            logic [N-DONE-1:0] bRemQ;

            if (k == 0) begin : gSrc
               assign aRemD = a[N-1:W];
               assign bRemD = bEff[N-1:W];
            end else begin : gSrc
               assign aRemD = gStage[k-1].gOps.aRemQ[N-k*W-1:W];
               assign bRemD = gStage[k-1].gOps.bRemQ[N-k*W-1:W];
            end

            always_ff @(posedge clk) begin
               if (rst) begin
                  aRemQ <= '0;
                  bRemQ <= '0;
               end else if (advance && validIn) begin
                  aRemQ <= aRemD;
                  bRemQ <= bRemD;
               end
            end
         end

         // Data loads only with a real beat, so bubbles leave the last result in place.
         always_ff @(posedge clk) begin
            if (rst) begin
               validQ <= 1'b0;
               resQ   <= '0;
               carryQ <= 1'b0;
            end else if (advance) begin
               validQ <= validIn;
               if (validIn) begin
                  resQ   <= resD;
                  carryQ <= carryD;
               end
            end
         end

`ifdef PIPE_ADDER_OVF_EN
         if (k == SEGS - 1) begin : gOvf
            logic ovfQ;

            // Carry into the sign bit is recovered as a ^ b ^ sum at that bit.
            always_ff @(posedge clk) begin
               if (rst) begin
                  ovfQ <= 1'b0;
               end else if (advance && validIn) begin
                  ovfQ <= aSeg[W-1] ^ bSeg[W-1] ^ segD[W-1] ^ carryD;
               end
            end
         end
`endif
      end
   endgenerate

   assign out_valid = gStage[SEGS-1].validQ;
   assign sum       = gStage[SEGS-1].resQ;
   assign cout      = gStage[SEGS-1].carryQ;

`ifdef PIPE_ADDER_OVF_EN
   assign ovf = gStage[SEGS-1].gOvf.ovfQ;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Testbench for pipe_adder: directed 8-bit/2-segment cases plus a randomized 32-bit/4-segment stream
// checked against an arithmetic reference model kept in a queue.
module tb_pipe_adder;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        o;
      int          acc;
   } exp_t;

   logic        clk;
   logic        rst;

   logic        iv8, ir8, ov8, or8, cin8, sub8, cout8;
   logic [7:0]  a8, b8, sum8;
   logic        iv32, ir32, ovl32, ordy32, cin32, sub32, cout32;
   logic [31:0] a32, b32, sum32;
`ifdef PIPE_ADDER_OVF_EN
   logic        ovf8, ovf32;
`endif

   int          checks = 0;
   int          errors = 0;
   int          cycleCnt = 0;
   int          accepted = 0;
   int          received = 0;
   logic        latChk = 1'b0;
   logic        holdPending = 1'b0;
   logic [31:0] holdSum;
   logic        holdCout;
   exp_t        expQ[$];

   pipe_adder #(.N(8), .SEGS(2)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(iv8), .in_ready(ir8),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .out_valid(ov8), .out_ready(or8),
      .sum(sum8), .cout(cout8)
`ifdef PIPE_ADDER_OVF_EN
      , .ovf(ovf8)
`endif
   );

   pipe_adder #(.N(32), .SEGS(4)) dut32 (
      .clk(clk), .rst(rst),
      .in_valid(iv32), .in_ready(ir32),
      .a(a32), .b(b32), .cin(cin32), .sub(sub32),
      .out_valid(ovl32), .out_ready(ordy32),
      .sum(sum32), .cout(cout32)
`ifdef PIPE_ADDER_OVF_EN
      , .ovf(ovf32)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached, got running want finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: exact integer arithmetic, signed overflow from the true signed result range.
   function automatic exp_t model32(input logic [31:0] x, input logic [31:0] y,
                                    input logic c, input logic s, input int cyc);
      exp_t   e;
      longint sx, sy, sr;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (s) begin
         e.s = x - y;
         e.c = (x >= y);
         sr  = sx - sy;
      end else begin
         {e.c, e.s} = {1'b0, x} + {1'b0, y} + 33'(c);
         sr = sx + sy + longint'(c);
      end
      e.o   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      e.acc = cyc;
      return e;
   endfunction

   task automatic randBeat32();
      a32   = $urandom();
      b32   = $urandom();
      cin32 = 1'($urandom_range(0, 1));
      sub32 = 1'($urandom_range(0, 1));
   endtask

   // One 32-bit cycle: inputs already set; observe handshakes mid-cycle, then move to next negedge.
   task automatic step32();
      logic expRdy;
      exp_t e;
      #1;
      cycleCnt++;
      if (holdPending) begin
         checks++;
         if (ovl32 !== 1'b1 || sum32 !== holdSum || cout32 !== holdCout) begin
            errors++;
            $display("[TB] FAIL hold: valid=%b sum=%h cout=%b want valid=1 sum=%h cout=%b",
                     ovl32, sum32, cout32, holdSum, holdCout);
         end
      end
      expRdy = !(ovl32 && !ordy32);
      checks++;
      if (ir32 !== expRdy) begin
         errors++;
         $display("[TB] FAIL in_ready: got %b want %b (out_valid=%b out_ready=%b)", ir32, expRdy, ovl32, ordy32);
      end
      if (iv32 && ir32) begin
         expQ.push_back(model32(a32, b32, cin32, sub32, cycleCnt));
         accepted++;
      end
      if (ovl32 && ordy32) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_result: got sum=%h want no output", sum32);
         end else begin
            e = expQ.pop_front();
            received++;
            if (sum32 !== e.s || cout32 !== e.c) begin
               errors++;
               $display("[TB] FAIL result32: got sum=%h cout=%b want sum=%h cout=%b", sum32, cout32, e.s, e.c);
            end
`ifdef PIPE_ADDER_OVF_EN
            checks++;
            if (ovf32 !== e.o) begin
               errors++;
               $display("[TB] FAIL ovf32: got %b want %b", ovf32, e.o);
            end
`endif
            if (latChk) begin
               checks++;
               if (cycleCnt - e.acc != 4) begin
                  errors++;
                  $display("[TB] FAIL latency32: got %0d want 4", cycleCnt - e.acc);
               end
            end
         end
      end
      holdPending = ovl32 && !ordy32;
      holdSum     = sum32;
      holdCout    = cout32;
      @(negedge clk);
   endtask

   task automatic drain32();
      int n = 0;
      iv32   = 1'b0;
      ordy32 = 1'b1;
      while (expQ.size() != 0 && n < 40) begin
         step32();
         n++;
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d results outstanding, want 0", expQ.size());
         expQ.delete();
      end
      repeat (3) step32();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (ovl32 !== 1'b0 || sum32 !== 32'h0 || cout32 !== 1'b0 || ir32 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset32: valid=%b sum=%h cout=%b ready=%b want 0 0 0 1", ovl32, sum32, cout32, ir32);
      end
      checks++;
      if (ov8 !== 1'b0 || sum8 !== 8'h0 || cout8 !== 1'b0 || ir8 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset8: valid=%b sum=%h cout=%b ready=%b want 0 0 0 1", ov8, sum8, cout8, ir8);
      end
   endtask

   task automatic test_add8();
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
      #1;
      checks++;
      if (ir8 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL add8_accept: in_ready got %b want 1", ir8);
      end
      @(negedge clk);
      iv8 = 1'b0;
      #1;
      checks++;
      if (ov8 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL add8_early: out_valid got %b want 0 one cycle after accept", ov8);
      end
      @(negedge clk);
      #1;
      checks++;
      if (ov8 !== 1'b1 || sum8 !== 8'h00 || cout8 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL add8_result: valid=%b sum=%h cout=%b want 1 00 1", ov8, sum8, cout8);
      end
`ifdef PIPE_ADDER_OVF_EN
      checks++;
      if (ovf8 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL add8_ovf: got %b want 0", ovf8);
      end
`endif
      @(negedge clk);
      #1;
      checks++;
      if (ov8 !== 1'b0 || sum8 !== 8'h00) begin
         errors++;
         $display("[TB] FAIL add8_single: valid=%b sum=%h want 0 00 (bubble holds last)", ov8, sum8);
      end
   endtask

   task automatic test_sub8();
      logic [7:0] va [2];
      logic [7:0] vb [2];
      logic [7:0] vs [2];
      logic       vc [2];
      va = '{8'h05, 8'h07};
      vb = '{8'h07, 8'h05};
      vs = '{8'hFE, 8'h02};
      vc = '{1'b0, 1'b1};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         a8 = va[i]; b8 = vb[i]; cin8 = 1'b1; sub8 = 1'b1; iv8 = 1'b1;
         @(negedge clk);
         iv8 = 1'b0;
         @(negedge clk);
         #1;
         checks++;
         if (ov8 !== 1'b1 || sum8 !== vs[i] || cout8 !== vc[i]) begin
            errors++;
            $display("[TB] FAIL sub8_%0d: valid=%b sum=%h cout=%b want 1 %h %b", i, ov8, sum8, cout8, vs[i], vc[i]);
         end
      end
   endtask

`ifdef PIPE_ADDER_OVF_EN
   task automatic test_ovf8();
      logic [7:0] va [2];
      logic [7:0] vs [2];
      logic       vsub [2];
      va   = '{8'h7F, 8'h80};
      vs   = '{8'h80, 8'h7F};
      vsub = '{1'b0, 1'b1};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         a8 = va[i]; b8 = 8'h01; cin8 = 1'b0; sub8 = vsub[i]; iv8 = 1'b1;
         @(negedge clk);
         iv8 = 1'b0;
         @(negedge clk);
         #1;
         checks++;
         if (ov8 !== 1'b1 || sum8 !== vs[i] || ovf8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf8_%0d: valid=%b sum=%h ovf=%b want 1 %h 1", i, ov8, sum8, ovf8, vs[i]);
         end
      end
   endtask
`endif

   task automatic test_back_to_back();
      @(negedge clk);
      accepted = 0; received = 0; latChk = 1'b1; ordy32 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         randBeat32();
         iv32 = 1'b1;
         step32();
      end
      drain32();
      latChk = 1'b0;
      checks++;
      if (accepted != 16 || received != 16) begin
         errors++;
         $display("[TB] FAIL b2b_count: accepted=%0d received=%0d want 16 16", accepted, received);
      end
   endtask

   task automatic test_backpressure();
      int stalls = 0;
      int n = 0;
      @(negedge clk);
      accepted = 0; received = 0; latChk = 1'b0;
      // Three beats back to back, then a fourth offered into the stall.
      while (received < 4 && n < 60) begin
         iv32 = (accepted < 4) && (n != 3);
         randBeat32();
         if (ovl32 && stalls < 5) begin
            ordy32 = 1'b0;
            stalls++;
         end else begin
            ordy32 = 1'b1;
         end
         step32();
         n++;
      end
      drain32();
      checks++;
      if (received != 4 || accepted != 4 || stalls != 5) begin
         errors++;
         $display("[TB] FAIL backpressure: received=%0d accepted=%0d stalls=%0d want 4 4 5", received, accepted, stalls);
      end
   endtask

   task automatic test_random_flow();
      @(negedge clk);
      accepted = 0; received = 0; latChk = 1'b0;
      for (int i = 0; i < 200; i++) begin
         iv32   = ($urandom_range(0, 3) != 0);
         ordy32 = ($urandom_range(0, 3) != 0);
         randBeat32();
         step32();
      end
      drain32();
      checks++;
      if (received != accepted || accepted == 0) begin
         errors++;
         $display("[TB] FAIL random_count: received=%0d accepted=%0d want equal and nonzero", received, accepted);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      accepted = 0; received = 0; latChk = 1'b0; ordy32 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         randBeat32();
         a32[31] = 1'b1;
         iv32 = 1'b1;
         step32();
      end
      iv32 = 1'b0;
      rst  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      expQ.delete();
      holdPending = 1'b0;
      #1;
      checks++;
      if (ovl32 !== 1'b0 || sum32 !== 32'h0 || cout32 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid: valid=%b sum=%h cout=%b want 0 0 0", ovl32, sum32, cout32);
      end
`ifdef PIPE_ADDER_OVF_EN
      checks++;
      if (ovf32 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid_ovf: got %b want 0", ovf32);
      end
`endif
      repeat (8) step32();
      received = 0;
      latChk = 1'b1;
      randBeat32();
      iv32 = 1'b1;
      step32();
      drain32();
      latChk = 1'b0;
      checks++;
      if (received != 1) begin
         errors++;
         $display("[TB] FAIL reset_mid_after: received=%0d want 1", received);
      end
   endtask

   initial begin
      rst = 1'b1;
      iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
      iv32 = 1'b0; ordy32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
      holdSum = '0; holdCout = 1'b0;
      test_reset();
      test_add8();
      test_sub8();
`ifdef PIPE_ADDER_OVF_EN
      test_ovf8();
`endif
      test_back_to_back();
      test_backpressure();
      test_random_flow();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
